dma_burst_ctrl: RTL and testbench

DMA_BURST_CTRL -- requirements
Module: dma_burst_ctrl

---
 rtl/dma_burst_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_dma_burst_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: one-shot copy engine. It reads N words into a local
// buffer with one read burst, then writes them back with one write burst.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   cmd_valid/ready  command handshake; ready only while idle
//   cmd_src/dst      source/destination bit addresses
//   cmd_size         size in bits; N = cmd_size[11:5] words
//   busy, done       status; done is a one-cycle pulse
//   m_addr           burst start bit address
//   m_renable/rsize  read burst strobe and size in bits
//   m_rdata          read data, captured from 2 edges after burst start
//   m_wenable/wsize  write burst strobe and size in bits
//   m_wdata          write data, word i driven from edge W+i
//   m_err            memory status; bit 1 aborts the write phase
module dma_burst_ctrl #(
   parameter int BUF_AW = 7
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_src,
   input  logic [31:0] cmd_dst,
   input  logic [11:0] cmd_size,
   output logic        busy,
   output logic        done,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   output logic        m_wenable,
   output logic        m_renable,
   output logic [11:0] m_wsize,
   output logic [11:0] m_rsize,
   input  logic [1:0]  m_err
);

   localparam int CW    = BUF_AW + 1;
   localparam int DEPTH = 1 << BUF_AW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_BURST,
      S_RD_DRAIN,
      S_GAP,
      S_WR_BURST,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     n_q, n_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [31:0]       dst_q, dst_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              ren_q, ren_d;
   logic              wen_q, wen_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [11:0]       rsize_q, rsize_d;
   logic [11:0]       wsize_q, wsize_d;

   logic [31:0]       buf_q [DEPTH];
   logic              buf_we;
   logic [BUF_AW-1:0] buf_widx;
   logic [BUF_AW-1:0] buf_ridx;

   logic [CW-1:0]     acc_n;
   logic [11:0]       acc_size;
   logic [CW-1:0]     cnt_nxt;

   // Sub-word size bits and m_err[0] carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{cmd_size[4:0], m_err[0]};

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign m_addr    = addr_q;
   assign m_wdata   = wdata_q;
   assign m_renable = ren_q;
   assign m_wenable = wen_q;
   assign m_rsize   = rsize_q;
   assign m_wsize   = wsize_q;

   // Word count, clamped to the buffer depth.
   always_comb begin
      if ({25'd0, cmd_size[11:5]} > 32'(DEPTH)) begin
         acc_n    = CW'(DEPTH);
         acc_size = 12'(DEPTH * 32);
      end else begin
         acc_n    = CW'(cmd_size[11:5]);
         acc_size = {cmd_size[11:5], 5'd0};
      end
   end

   // Read: cnt counts cycles since burst start; word (cnt-1) arrives.
   // Write: word cnt+1 is loaded while word cnt is being sampled.
   assign cnt_nxt  = cnt_q + CW'(1);
   assign buf_widx = BUF_AW'(cnt_q - CW'(1));
   assign buf_ridx = BUF_AW'(cnt_nxt);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      dst_d   = dst_q;
      err_d   = err_q;
      done_d  = 1'b0;
      ren_d   = ren_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rsize_d = rsize_q;
      wsize_d = wsize_q;
      buf_we  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               dst_d = cmd_dst;
               n_d   = acc_n;
               cnt_d = '0;
               err_d = 1'b0;
               if (acc_n == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RD_BURST;
                  ren_d   = 1'b1;
                  addr_d  = cmd_src;
                  rsize_d = acc_size;
               end
            end
         end
         S_RD_BURST: begin
            err_d = err_q | m_err[1];
            if (cnt_q != '0) begin
               buf_we = 1'b1;
            end
            if (cnt_q == n_q) begin
               state_d = S_RD_DRAIN;
               ren_d   = 1'b0;
            end else begin
               cnt_d = cnt_nxt;
            end
         end
         S_RD_DRAIN: begin
            if (err_q | m_err[1]) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_WR_BURST;
            wen_d   = 1'b1;
            addr_d  = dst_q;
            wsize_d = rsize_q;
            wdata_d = buf_q[0];
            cnt_d   = '0;
         end
         S_WR_BURST: begin
            if (cnt_q == n_q) begin
               state_d = S_DONE;
               wen_d   = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_nxt;
               if (cnt_nxt < n_q) begin
                  wdata_d = buf_q[buf_ridx];
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
         dst_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rsize_q <= '0;
         wsize_q <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         dst_q   <= dst_d;
         err_q   <= err_d;
         done_q  <= done_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rsize_q <= rsize_d;
         wsize_q <= wsize_d;
      end
   end

   // Buffer contents survive reset.
   always_ff @(posedge clk) begin
      if (rstn && buf_we) begin
         buf_q[buf_widx] <= m_rdata;
      end
   end

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// tb_dma_burst_ctrl: table vectors, corner sequences and random copies
// checked against a word-level memory model and phase-length arithmetic.
module tb_dma_burst_ctrl;

   logic        clk;
   logic        rstn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_src;
   logic [31:0] cmd_dst;
   logic [11:0] cmd_size;
   logic        busy;
   logic        done;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_wenable;
   logic        m_renable;
   logic [11:0] m_wsize;
   logic [11:0] m_rsize;
   logic [1:0]  m_err;

   dma_burst_ctrl #(.BUF_AW(7)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .cmd_size  (cmd_size),
      .busy      (busy),
      .done      (done),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata),
      .m_wenable (m_wenable),
      .m_renable (m_renable),
      .m_wsize   (m_wsize),
      .m_rsize   (m_rsize),
      .m_err     (m_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          sw;
      int          dw;
      logic [11:0] size;
      int          err_k;
      logic [11:0] rsz;
      int          dk;
      bit          wr;
   } vec_t;

   int          vec    = 0;
   int          miscmp = 0;
   int          n_rrise = 0;
   int          n_wrise = 0;
   int          n_done  = 0;
   logic [11:0] seen_rsize;
   logic [11:0] seen_wsize;
   bit          mon_on = 0;
   logic [31:0] mem [4096];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   // Memory slave plus per-cycle protocol checker.
   task automatic mon_loop();
      bit          ren_p = 0;
      bit          wen_p = 0;
      logic [31:0] addr_p = '0;
      logic [11:0] rsz_p = '0;
      logic [11:0] wsz_p = '0;
      int          rk = 0;
      int          wk = 0;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            chk("dual_enable", {31'd0, m_renable & m_wenable}, 32'd0);
            if (m_renable && ren_p) begin
               chk("raddr_stable", m_addr, addr_p);
               chk("rsize_stable", {20'd0, m_rsize}, {20'd0, rsz_p});
            end
            if (m_wenable && wen_p) begin
               chk("waddr_stable", m_addr, addr_p);
               chk("wsize_stable", {20'd0, m_wsize}, {20'd0, wsz_p});
            end
            if (done) n_done++;
            if (m_renable) begin
               if (!ren_p) begin
                  n_rrise++;
                  seen_rsize = m_rsize;
                  rk = 0;
               end else begin
                  rk++;
               end
               if (rk >= 1)
                  m_rdata = mem[12'(int'(m_addr[16:5]) + rk - 1)];
            end
            if (m_wenable) begin
               if (!wen_p) begin
                  n_wrise++;
                  seen_wsize = m_wsize;
                  wk = 0;
               end else begin
                  wk++;
               end
               if (wk < int'(m_wsize[11:5]))
                  mem[12'(int'(m_addr[16:5]) + wk)] = m_wdata;
            end
         end
         ren_p  = m_renable;
         wen_p  = m_wenable;
         addr_p = m_addr;
         rsz_p  = m_rsize;
         wsz_p  = m_wsize;
      end
   endtask

   // Reference rules: read phase occupies cycles 1..N+2 after accept,
   // then a 1-cycle gap, then N+1 write cycles, then DONE.
   function automatic int n_of(input logic [11:0] s);
      int n;
      n = int'(s[11:5]);
      return (n > 128) ? 128 : n;
   endfunction

   function automatic bit skips(input int n, input int ek);
      return (n > 0) && (ek >= 1) && (ek <= n + 2);
   endfunction

   function automatic int done_at(input int n, input int ek);
      if (n == 0) return 1;
      if (skips(n, ek)) return n + 3;
      return 2 * n + 5;
   endfunction

   task automatic do_cmd(input int sw, input int dw,
                         input logic [11:0] size, input int err_k,
                         output int done_k);
      done_k    = -1;
      cmd_src   = 32'(sw * 32);
      cmd_dst   = 32'(dw * 32);
      cmd_size  = size;
      cmd_valid = 1'b1;
      chk("ready_idle", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (done && done_k < 0) done_k = k;
         m_err = {k == err_k, 1'($urandom_range(0, 1))};
         if (done_k >= 0 && k > done_k) break;
      end
      m_err = 2'b00;
      if (done_k < 0) begin
         vec++;
         miscmp++;
         $display("FAIL done_timeout: got none, want a pulse");
      end
   endtask

   task automatic run_xfer(input string tag, input int sw, input int dw,
                           input logic [11:0] size, input int err_k,
                           input logic [11:0] ersz, input int edk,
                           input bit ewr);
      int          r0, w0, d0, dk, n;
      logic [31:0] snap [4096];
      logic [31:0] ew;
      snap = mem;
      r0 = n_rrise;
      w0 = n_wrise;
      d0 = n_done;
      n  = n_of(size);
      do_cmd(sw, dw, size, err_k, dk);
      chk({tag, "/done_at"}, dk, edk);
      chk({tag, "/done_cnt"}, n_done - d0, 1);
      chk({tag, "/rd_bursts"}, n_rrise - r0, (n > 0) ? 1 : 0);
      chk({tag, "/wr_bursts"}, n_wrise - w0, ewr ? 1 : 0);
      if (n > 0) chk({tag, "/rsize"}, {20'd0, seen_rsize}, {20'd0, ersz});
      if (ewr) chk({tag, "/wsize"}, {20'd0, seen_wsize}, {20'd0, ersz});
      for (int i = 0; i < n; i++) begin
         ew = ewr ? snap[12'(sw + i)] : snap[12'(dw + i)];
         chk({tag, "/dst_word"}, mem[12'(dw + i)], ew);
      end
   endtask

   vec_t tbl [9];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          dk, n, ek, sw, dw, first, second, wc, d0, r0, w0;
      logic [11:0] sz;
      bit          hit;
      tbl[0] = '{0,     'h80,  12'd128,  0, 12'h080, 13,  1};
      tbl[1] = '{'h10,  'h90,  12'd31,   0, 12'h000, 1,   0};
      tbl[2] = '{0,     'h400, 12'd4095, 0, 12'hFE0, 259, 1};
      tbl[3] = '{'h20,  'ha0,  12'd32,   0, 12'h020, 7,   1};
      tbl[4] = '{'h30,  'hb0,  12'd71,   0, 12'h040, 9,   1};
      tbl[5] = '{'h40,  'hc0,  12'd128,  2, 12'h080, 7,   0};
      tbl[6] = '{'h40,  'hc8,  12'd128,  6, 12'h080, 7,   0};
      tbl[7] = '{'h40,  'hd0,  12'd128,  7, 12'h080, 13,  1};
      tbl[8] = '{'h48,  'hd8,  12'd140, 10, 12'h080, 13,  1};

      m_rdata   = '0;
      m_err     = 2'b00;
      cmd_valid = 1'b0;
      cmd_src   = '0;
      cmd_dst   = '0;
      cmd_size  = '0;
      rstn      = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
      fork
         mon_loop();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst/cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst/busy", {31'd0, busy}, 32'd0);
      chk("rst/done", {31'd0, done}, 32'd0);
      chk("rst/renable", {31'd0, m_renable}, 32'd0);
      chk("rst/wenable", {31'd0, m_wenable}, 32'd0);
      chk("rst/addr", m_addr, 32'd0);
      chk("rst/wdata", m_wdata, 32'd0);
      chk("rst/rsize", {20'd0, m_rsize}, 32'd0);
      chk("rst/wsize", {20'd0, m_wsize}, 32'd0);
      rstn   = 1'b1;
      mon_on = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 9; t++) begin
         run_xfer($sformatf("tbl%0d", t), tbl[t].sw, tbl[t].dw,
                  tbl[t].size, tbl[t].err_k, tbl[t].rsz, tbl[t].dk,
                  tbl[t].wr);
         if (t == 0) begin
            for (int i = 0; i < 4; i++)
               chk("copy_a0", mem[12'h80 + 12'(i)], 32'hA0 + 32'(i));
         end
      end

      // Back-to-back with cmd_valid held: second accept waits for IDLE.
      first  = -1;
      second = -1;
      r0 = n_rrise;
      w0 = n_wrise;
      d0 = n_done;
      cmd_src   = 32'h100 * 32;
      cmd_dst   = 32'h180 * 32;
      cmd_size  = 12'd64;
      cmd_valid = 1'b1;
      for (int j = 0; j <= 10; j++) begin
         if (cmd_ready) begin
            if (first < 0) first = j;
            else if (second < 0) second = j;
         end
         if (j < 10) @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      hit = 0;
      for (int k = 0; k < 40 && !hit; k++) begin
         if (done) hit = 1;
         @(negedge clk);
      end
      @(negedge clk);
      chk("b2b/first_accept", first, 0);
      chk("b2b/second_accept", second, 10);
      chk("b2b/rd_bursts", n_rrise - r0, 2);
      chk("b2b/wr_bursts", n_wrise - w0, 2);
      chk("b2b/done_cnt", n_done - d0, 2);

      // Reset while word 2 of the write burst is on m_wdata.
      cmd_src   = 32'h200 * 32;
      cmd_dst   = 32'h300 * 32;
      cmd_size  = 12'd256;
      cmd_valid = 1'b1;
      @(posedge clk);
      wc  = 0;
      hit = 0;
      for (int k = 0; k < 100 && !hit; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (m_wenable) begin
            if (wc == 2) hit = 1;
            else wc++;
         end
      end
      chk("rstmid/reached_word2", {31'd0, hit}, 32'd1);
      d0   = n_done;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("rstmid/wenable", {31'd0, m_wenable}, 32'd0);
      chk("rstmid/busy", {31'd0, busy}, 32'd0);
      chk("rstmid/done", {31'd0, done}, 32'd0);
      chk("rstmid/cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rstmid/addr", m_addr, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      chk("rstmid/no_done", n_done - d0, 0);

      // Random copies with random status-error injection.
      for (int r = 0; r < 30; r++) begin
         n  = (r % 10 == 9) ? $urandom_range(100, 127)
                            : $urandom_range(0, 12);
         sz = {7'(n), 5'($urandom_range(0, 31))};
         sw = $urandom_range(0, 3900);
         dw = $urandom_range(0, 3900);
         ek = $urandom_range(0, 1) ? $urandom_range(1, 2 * n + 6) : 0;
         run_xfer($sformatf("rnd%0d", r), sw, dw, sz, ek,
                  12'(n_of(sz) * 32), done_at(n_of(sz), ek),
                  (n_of(sz) > 0) && !skips(n_of(sz), ek));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
